// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS divide unit: FSM state encoding and default width.
package mips_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem stays below divisor, so the W+1-bit difference never overflows and its MSB is the borrow
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle MIPS DIV/DIVU unit (restoring, one bit per cycle).
// Signed DIV support is built only when MIPS_DIV_SIGNED_EN is defined.
module mips_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned    CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvs_r),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

`ifdef MIPS_DIV_SIGNED_EN
  logic             neg_q, neg_r, dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  // divide-by-zero keeps the raw all-ones quotient rather than a sign-corrected one
  always_comb begin
    dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    quo_fix = neg_q ? -quo_r : quo_r;
    rem_fix = neg_r ? -rem_r : rem_r;
    if (dvs_zero) quo_fix = '1;
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  always_comb begin
    quo_fix = quo_r;
    rem_fix = rem_r;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef MIPS_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
            rem_r <= '0;
`ifdef MIPS_DIV_SIGNED_EN
            quo_r    <= dvd_mag;
            dvs_r    <= dvs_mag;
            neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= is_signed & dividend[WIDTH-1];
            dvs_zero <= is_signed & (divisor == '0);
`else
            quo_r <= dividend;
            dvs_r <= divisor;
`endif
          end
        end
        CALC: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          if (cnt == LAST_STEP) state <= FIX;
          else                  cnt   <= cnt + 1'b1;
        end
        FIX: begin
          quotient  <= quo_fix;
          remainder <= rem_fix;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed bench for mips_div_unit: scoreboard of expected results checked on each done pulse.
module tb_mips_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, is_signed;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;

  mips_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           edge_no;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   d0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r);
    exp_t e;
    e.q = q; e.r = r; e.edge_no = 0;
    return e;
  endfunction

  function automatic exp_t model_u(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return mk('1, a);
    return mk(a / b, a % b);
  endfunction

`ifdef MIPS_DIV_SIGNED_EN
  function automatic exp_t model_s(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    if (b == '0) return mk('1, a);
    if (a == most_neg && b == '1) return mk(most_neg, '0);
    return mk(W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b)));
  endfunction
`endif

  // Called at posedge+#1; start is sampled on the following edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input exp_t e, input logic accepted);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (accepted) begin
      e.edge_no = cyc + 1 + W + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    checks++;
    assert (sb.size() == 0 && !busy) else begin
      errors++;
      $error("FAIL %s_timeout: got pending=%0d busy=%b expected pending=0 busy=0", tag, sb.size(), busy);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_done: got done=1 expected no done (nothing pending)");
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("latency_edge", W'(cyc), W'(mon_e.edge_no));
        check("busy_at_done", W'(busy), '0);
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    rst = 1'b0;

    // basic unsigned
    start_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2), 1'b1);
    check("busy_after_start", W'(busy), W'(1));
    wait_idle("unsigned_100_7");

    // divide by zero
    start_op(32'h0000_1234, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'h0000_1234), 1'b1);
    wait_idle("div_zero");
    repeat (5) @(posedge clk);
    #1;
    check("hold_quotient", quotient, 32'hFFFF_FFFF);
    check("hold_remainder", remainder, 32'h0000_1234);

    // start while busy is ignored
    d0 = done_cnt;
    start_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start_op(32'd9, 32'd3, 1'b0, mk('0, '0), 1'b0);
    wait_idle("busy_start");
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_done_count", W'(done_cnt - d0), W'(1));

    // reset in the middle of CALC
    d0 = done_cnt;
    start_op(32'd5000, 32'd3, 1'b0, mk('0, '0), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", W'(busy), '0);
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_done", W'(done_cnt - d0), '0);
    start_op(32'd1000, 32'd10, 1'b0, mk(32'd100, 32'd0), 1'b1);
    wait_idle("after_midrst");

    // reset wins over start
    rst = 1'b1; start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", W'(busy), '0);
    check("rst_prio_quotient", quotient, '0);
    repeat (40) @(posedge clk);
    #1;

    // back-to-back: restart in the done cycle
    start_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2), 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("b2b_done_seen", W'(done), W'(1));
    start_op(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0), 1'b1);
    check("b2b_busy", W'(busy), W'(1));
    wait_idle("back_to_back");

    // boundaries
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, mk(32'hFFFF_FFFF, 32'd0), 1'b1);
    wait_idle("max_div_1");
    start_op(32'd5, 32'hFFFF_FFFF, 1'b0, mk(32'd0, 32'd5), 1'b1);
    wait_idle("small_div_max");
    start_op(32'd0, 32'd5, 1'b0, mk(32'd0, 32'd0), 1'b1);
    wait_idle("zero_dividend");

`ifdef MIPS_DIV_SIGNED_EN
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF), 1'b1);
    wait_idle("s_m7_2");
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0), 1'b1);
    wait_idle("s_min_m1");
    start_op(32'hFFFF_FFFB, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'hFFFF_FFFB), 1'b1);
    wait_idle("s_div_zero");
    start_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, mk(32'd3, 32'hFFFF_FFFF), 1'b1);
    wait_idle("s_m7_m2");
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1), 1'b1);
    wait_idle("s_7_m2");
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      start_op(a, b, 1'b1, model_s(a, b), 1'b1);
      wait_idle("s_random");
    end
`else
    // is_signed has no effect in this build
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'h7FFF_FFFC, 32'd1), 1'b1);
    wait_idle("u_signed_ignored");
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'd0, 32'h8000_0000), 1'b1);
    wait_idle("u_min_max");
`endif

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 20)) : $urandom;
      start_op(a, b, 1'b0, model_u(a, b), 1'b1);
      wait_idle("u_random");
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_div_unit.md
MIPS_DIV_UNIT -- requirements
Module: mips_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port is_signed  input  1  1 = DIV (signed), 0 = DIVU (unsigned).
REQ-007 SHALL have port dividend  input  WIDTH  numerator (rs); sampled with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator (rt); sampled with start.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results are updated.
REQ-011 SHALL have port quotient  output  WIDTH  LO result, registered.
REQ-012 SHALL have port remainder  output  WIDTH  HI result, registered.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and FIX.
REQ-014 SHALL move IDLE->CALC on the edge where start=1, latching operands and is_signed, and SHALL set busy=1 and the step counter to 0.
REQ-015 SHALL, in CALC, perform one restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor from rem, keep the result if non-negative and set quo LSB=1, else restore and set LSB=0.
REQ-016 SHALL go CALC->FIX after exactly WIDTH steps; counter wrap SHALL NOT occur.
REQ-017 SHALL, in FIX, apply sign correction, write quotient/remainder, pulse done=1 for one cycle, clear busy, and return to IDLE.
REQ-018 SHALL give latency: start sampled at edge N -> done and new results visible after edge N+WIDTH+1.
REQ-019 SHALL accept a new start in the cycle done is high, because the FSM is then in IDLE.
REQ-020 SHALL ignore start while busy=1, with no effect on state, operands or outputs.
REQ-021 SHALL hold quotient/remainder stable between done pulses.
REQ-022 SHALL, for divisor=0, return quotient = all ones and remainder = dividend, with normal latency and no exception.
REQ-023 SHALL, for signed division, divide magnitudes, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-024 SHALL, for signed most-negative/-1, return quotient = most-negative and remainder = 0.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, go to IDLE and set busy=0, done=0, quotient=0, remainder=0 and counter=0.
REQ-026 SHALL abort an in-flight division on mid-operation reset; no done pulse SHALL follow.
REQ-027 SHALL give rst priority over start in the same cycle.

Configuration
REQ-028 SHALL use macro MIPS_DIV_SIGNED_EN: when defined, is_signed selects signed handling per REQ-023/REQ-024.
REQ-029 SHALL, without MIPS_DIV_SIGNED_EN, ignore is_signed, treat all operands as unsigned, and contain no sign-correction logic.

Structure
REQ-030 SHALL take the state encoding (IDLE, CALC, FIX) and the WIDTH default constant from shared package mips_pkg.
REQ-031 SHALL place one restoring step in a combinational sub-module div_step (inputs rem, quo, divisor; outputs next rem, next quo), instantiated once.

Verification
REQ-032 Unsigned: start, dividend=100, divisor=7 -> done after 33 cycles, quotient=14, remainder=2.
REQ-033 Divide by zero: dividend=0x0000_1234, divisor=0 -> quotient=0xFFFF_FFFF, remainder=0x0000_1234.
REQ-034 Signed (macro on): -7 / 2 -> quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1); 0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0.
REQ-035 Start while busy: second start at cycle 5 with 9/3 -> ignored; first result (100/7) delivered unchanged, exactly one done pulse.
REQ-036 Reset mid-op: rst at cycle 10 of CALC -> next cycle busy=0, quotient=0, remainder=0; no done pulse; a new start then completes normally.
REQ-037 Back-to-back: start asserted in the done cycle -> second operation is accepted, and its done follows 33 cycles later.
